// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared funct codes, widths and FSM state type for the HI/LO multiply/divide unit.
// The funct codes match the MIPS SPECIAL encodings used by the rest of the ISA.
package hilo_muldiv_ctrl_pkg;

    localparam int WORD = 32;
    localparam int FUN  = 6;

    localparam logic [FUN-1:0] FUN_MTHI  = 6'h11;
    localparam logic [FUN-1:0] FUN_MTLO  = 6'h13;
    localparam logic [FUN-1:0] FUN_MULT  = 6'h18;
    localparam logic [FUN-1:0] FUN_MULTU = 6'h19;
    localparam logic [FUN-1:0] FUN_DIV   = 6'h1A;
    localparam logic [FUN-1:0] FUN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [FUN-1:0] f);
        return (f == FUN_MULT) || (f == FUN_MULTU) || (f == FUN_DIV) || (f == FUN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 multiply/divide datapath working on operand magnitudes.
// Results are sign-corrected combinationally; the controller samples them in FIN.
module muldiv_core
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [FUN-1:0]  funct,
    input  logic [WORD-1:0] opa,
    input  logic [WORD-1:0] opb,
    output logic [WORD-1:0] res_hi,
    output logic [WORD-1:0] res_lo
);

    logic [WORD-1:0] acc_hi, acc_lo, mag_b, raw_a;
    logic            div_op, neg_main, neg_rem, div_zero;

    logic            signed_op, sign_a, sign_b;
    logic [WORD-1:0] mag_a_in, mag_b_in;
    logic [WORD:0]   add_sum, shifted;
    logic [WORD+1:0] diff;
    logic [2*WORD-1:0] prod, prod_s;
    logic [WORD-1:0] quot_s, rem_s;

    assign signed_op = (funct == FUN_MULT) || (funct == FUN_DIV);
    assign sign_a    = signed_op & opa[WORD-1];
    assign sign_b    = signed_op & opb[WORD-1];
    assign mag_a_in  = sign_a ? -opa : opa;
    assign mag_b_in  = sign_b ? -opb : opb;

    // Multiply: conditional add of the multiplicand, then shift {carry,acc_hi,acc_lo} right.
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WORD+1){1'b0}});
    // Divide: shift remainder left by one dividend bit, trial-subtract, restore on borrow.
    assign shifted = {acc_hi, acc_lo[WORD-1]};
    assign diff    = {1'b0, shifted} - {2'b00, mag_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            raw_a    <= '0;
            div_op   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= mag_a_in;
            mag_b    <= mag_b_in;
            raw_a    <= opa;
            div_op   <= (funct == FUN_DIV) || (funct == FUN_DIVU);
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (opb == '0);
        end else if (step) begin
            if (div_op) begin
                acc_hi <= diff[WORD+1] ? shifted[WORD-1:0] : diff[WORD-1:0];
                acc_lo <= {acc_lo[WORD-2:0], ~diff[WORD+1]};
            end else begin
                acc_hi <= add_sum[WORD:1];
                acc_lo <= {add_sum[0], acc_lo[WORD-1:1]};
            end
        end
    end

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_main ? -prod : prod;
    assign quot_s = neg_main ? -acc_lo : acc_lo;
    assign rem_s  = neg_rem  ? -acc_hi : acc_hi;

    always_comb begin
        res_hi = prod_s[2*WORD-1:WORD];
        res_lo = prod_s[WORD-1:0];
        if (div_op) begin
            // Divide by zero reports the raw dividend and an all-ones quotient.
            res_hi = div_zero ? raw_a : rem_s;
            res_lo = div_zero ? {WORD{1'b1}} : quot_s;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: sequencing FSM, step counter and the HI/LO registers.
//   state | meaning
//   IDLE  | accepting mult/div starts and MTHI/MTLO writes
//   CALC  | one radix-2 step per cycle, counter 0..31
//   FIN   | done pulse; HI/LO written at the end of this cycle
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [FUN-1:0]  funct,
    input  logic [WORD-1:0] opA,
    input  logic [WORD-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] hi,
    output logic [WORD-1:0] lo
);

    state_t          state;
    logic [4:0]      cnt;
    logic            load, step;
    logic [WORD-1:0] res_hi, res_lo;

    assign load = (state == ST_IDLE) && start && is_muldiv(funct);
    assign step = (state == ST_CALC);
    assign busy = (state != ST_IDLE);

    muldiv_core u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .funct  (funct),
        .opa    (opA),
        .opb    (opB),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_muldiv(funct)) begin
                            state <= ST_CALC;
                            cnt   <= '0;
                        end else if (funct == FUN_MTHI) begin
                            hi <= opA;
                        end else if (funct == FUN_MTLO) begin
                            lo <= opA;
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && state == ST_IDLE && start && !is_muldiv(funct)
            && funct != FUN_MTHI && funct != FUN_MTLO)
            $warning("hilo_muldiv_ctrl: unknown funct %h ignored", funct);
    end
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a cycle-level reference model and literal spot checks.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] opA = '0, opB = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;

    hilo_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result of an operation, from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        if (f == FUN_MULTU) begin
            res = {32'b0, a} * {32'b0, b};
        end else if (f == FUN_MULT) begin
            res = sa * sb;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (f == FUN_DIVU) begin
            res = {a % b, a / b};
        end else begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Model: phase counts cycles since acceptance; done in phase 33, HI/LO land on leaving it.
    int          phase = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase = 0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (phase == 0) begin
            if (start) begin
                if (is_muldiv(funct)) begin
                    pend  = ref_result(funct, opA, opB);
                    phase = 1;
                end else if (funct == FUN_MTHI) m_hi = opA;
                else if (funct == FUN_MTLO) m_lo = opA;
            end
        end else if (phase < 33) begin
            phase++;
        end else begin
            m_hi  = pend[63:32];
            m_lo  = pend[31:0];
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", {31'b0, busy}, {31'b0, (phase != 0)});
            chk("done", {31'b0, done}, {31'b0, (phase == 33)});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (done) done_cnt++;
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; funct = f; opA = a; opB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int d0;
        d0 = done_cnt;
        issue(f, a, b);
        wait_idle();
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_dones"}, done_cnt - d0, 32'd1);
    endtask

    initial begin
        int d0;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        run_op("multu_max", FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  FUN_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min",  FUN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",   FUN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", FUN_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF);
        run_op("div_zero",  FUN_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",   FUN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        run_op("divu_std",  FUN_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);
        run_op("div_remsg", FUN_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);

        issue(FUN_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_done", {31'b0, done}, 32'd0);
        issue(FUN_MTLO, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_F00D);

        issue(6'h3F, 32'h5555_5555, 32'd1);
        chk("bad_funct_busy", {31'b0, busy}, 32'd0);
        chk("bad_funct_hi", hi, 32'h1234_5678);

        issue(FUN_MULTU, 32'd2, 32'd3);
        issue(FUN_MTHI, 32'hDEAD_BEEF, 32'd0);
        wait_idle();
        chk("mthi_busy_hi", hi, 32'd0);
        chk("mthi_busy_lo", lo, 32'd6);

        // Reset while counter is at 15.
        issue(FUN_MULTU, 32'd5, 32'd5);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_nodone", done_cnt - d0, 32'd0);
        run_op("post_rst", FUN_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        // Start held high across FIN.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; funct = FUN_MULTU; opA = 32'd6; opB = 32'd7;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("b2b_done_seen", seen, 32'd1);
        funct = FUN_DIVU; opA = 32'd100; opB = 32'd7;
        @(negedge clk);
        chk("b2b_first_lo", lo, 32'd42);
        chk("b2b_idle_gap", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", {31'b0, busy}, 32'd1);
        wait_idle();
        chk("b2b_second_hi", hi, 32'd2);
        chk("b2b_second_lo", lo, 32'd14);
        chk("b2b_dones", done_cnt - d0, 32'd2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as in the rest of the codebase: clk, reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- start  in  1  request valid, sampled on clk rise
- funct  in  `FUN (6)  operation: FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO
- opA  in  `WORD (32)  rs operand / dividend / multiplicand
- opB  in  `WORD (32)  rt operand / divisor / multiplier
- busy  out  1  operation in flight; the pipeline stalls MFHI/MFLO/new mult-div while high
- done  out  1  one-cycle pulse when HI/LO are updated by mult/div
- hi  out  `WORD  HI register
- lo  out  `WORD  LO register
REQ-003 The block SHALL have no parameters; width is fixed by `WORD.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC, FIN. busy SHALL equal (state != IDLE).
REQ-005 In IDLE, start=1 with funct in {MULT, MULTU, DIV, DIVU} SHALL latch the operands and the operation, clear a 5-bit counter, and move to CALC.
REQ-006 In IDLE, start=1 with MTHI or MTLO SHALL write opA to hi or lo respectively at that edge, with busy and done staying 0.
REQ-007 In IDLE, start=1 with any other funct SHALL be ignored (simulation $warning), leaving state unchanged.
REQ-008 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) on operand magnitudes for 32 cycles (counter 0..31), then move to FIN.
REQ-009 FIN SHALL apply sign correction, write hi/lo, assert done for exactly that cycle, and return to IDLE.
REQ-010 Latency: if start is accepted at edge T, done SHALL be high in the cycle after edge T+32, hi/lo SHALL be valid from edge T+33, and busy SHALL be high in the cycles after edges T..T+32.
REQ-011 MULT/MULTU: {hi,lo} SHALL be the 64-bit signed or unsigned product respectively.
REQ-012 DIV/DIVU: lo SHALL be the quotient truncated toward zero and hi the remainder; for signed operations the remainder sign SHALL follow the dividend.
REQ-013 Divide by zero SHALL give hi=opA and lo=32'hFFFFFFFF (signed and unsigned) with the same latency.
REQ-014 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-015 start while busy SHALL be ignored, including MTHI/MTLO; the requester holds start until busy=0.
REQ-016 hi/lo SHALL hold their value except on the writes in REQ-006 and REQ-009.
REQ-017 start in the FIN cycle SHALL be ignored; it is accepted on the next cycle in IDLE.

Reset
REQ-018 reset=1 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, including mid-CALC; the in-flight operation SHALL be discarded.
REQ-019 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-020 FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO SHALL be defined in ISA.v next to the existing FUN_* codes; the block SHALL contain no local opcode literals.
REQ-021 The iterative datapath (accumulator, shifter, add/subtract, magnitude/sign logic) SHALL be one sub-module, muldiv_core; hilo_muldiv_ctrl SHALL hold the FSM, counter and HI/LO registers.
REQ-022 The ALU's FUN_MULT/FUN_MULTU path SHALL be bypassed once this block is integrated; MFHI/MFLO read hi/lo.

Verification
REQ-023 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done once after 33 cycles; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-024 MULT 32'hFFFFFFFD(-3) x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB(-21).
REQ-025 DIV -7 / 2 -> lo=32'hFFFFFFFD(-3), hi=32'hFFFFFFFF(-1); DIVU 100/0 -> hi=100, lo=32'hFFFFFFFF.
REQ-026 MTHI 32'h12345678 in IDLE -> hi updated next edge, busy=0, done=0; the same request issued while busy -> no change.
REQ-027 reset pulsed at CALC counter=15 -> busy=0, hi=lo=0 immediately; no done pulse follows; a new MULTU 3x4 then gives lo=12.
REQ-028 Back-to-back: start held high across FIN -> second operation accepted one cycle after done; exactly one done pulse per operation.
